halfband_chan_sched: RTL
========================

# halfband_chan_sched

Time-division scheduler that shares one multichannel halfband decimation filter core among NCH PCM channels in the delta-sigma decimation chain. It captures one 24-bit sample per channel per input sample period. It feeds the captured samples to the filter's AXI-stream slave in strict channel order 0..NCH-1, as the core's interleaved-channel configuration requires. It demultiplexes the in-order 32-bit filter outputs back to per-channel 24-bit outputs, with saturation and sticky overrun/saturation flags.

## Interface

- NCH, 2, number of channels sharing the filter (2..8)
- DW, 24, PCM sample width (filter input and block output)
- FW, 32, filter output width
- clk  input  1  single clock for all logic
- rst  input  1  synchronous, active-high reset
- in_data  input  NCH*DW  channel i sample at bits [i*DW +: DW], signed
- in_valid  input  NCH  one-cycle strobe per channel; captures in_data slice
- f_tdata  output  DW  to filter s_axis_data_tdata
- f_tvalid  output  1  to filter s_axis_data_tvalid
- f_tready  input  1  from filter s_axis_data_tready
- f_m_tdata  input  FW  from filter m_axis_data_tdata, signed
- f_m_tvalid  input  1  from filter m_axis_data_tvalid
- out_data  output  NCH*DW  per-channel filtered, saturated sample, held until next update
- out_valid  output  NCH  one-cycle strobe per channel on update
- overrun  output  NCH  sticky: sample lost on channel i
- sat  output  NCH  sticky: output of channel i was clipped
- clr_flags  input  1  clears overrun and sat

## Operation

- Per channel: holding register buf[i] and flag full[i].
- in_valid[i] loads buf[i] and sets full[i].
- in_valid[i] while full[i] is set and not being consumed that cycle: buf[i] is overwritten with the new sample, full[i] stays 1, overrun[i] is set.
- Issue pointer sel, range 0..NCH-1:
  - f_tvalid = full[sel] and f_tdata = buf[sel], both driven from registers with no combinational path from in_*.
  - On f_tvalid && f_tready: full[sel] clears and sel advances (NCH-1 wraps to 0).
- Same-cycle consume and in_valid[sel]: new sample loads, full[sel] remains 1, no overrun.
- sel never skips a channel. An empty channel stalls all issue until it fills, which keeps the core's channel interleave aligned.
- Output pointer ochan, range 0..NCH-1, advances on each f_m_tvalid and wraps NCH-1 to 0. The filter returns outputs in channel order.
- Saturation of f_m_tdata (signed FW) to DW:
  - Above 8388607: output 24'h7FFFFF and set sat[ochan].
  - Below -8388608: output 24'h800000 and set sat[ochan].
  - Otherwise: output f_m_tdata[23:0].
- clr_flags clears all overrun and sat bits. If a flag is set in the same cycle, the set wins.
- rst must be asserted together with the filter core reset. A reset mid-operation discards held samples and realigns both pointers to channel 0.

## Timing

- Reset values:
  - f_tvalid=0, f_tdata=0
  - out_data=0, out_valid=0
  - overrun=0, sat=0
  - full=0, sel=0, ochan=0
- Capture: in_valid[i] at edge t gives full[i]=1 after t. If sel==i, f_tvalid=1 in cycle t+1.
- Issue: handshake at edge t gives the next channel's f_tvalid/f_tdata in cycle t+1. Back-to-back issue at one sample per cycle is possible when all channels are full and f_tready=1.
- f_tvalid, once high, stays high and f_tdata stays stable until the handshake. An overwrite on overrun may change f_tdata while valid; this is an accepted error condition and is flagged.
- Output: f_m_tvalid at edge t gives out_data[ochan] updated and out_valid[ochan]=1 for exactly cycle t+1. Latency is 1 cycle.
- out_valid is one-hot or zero.
- f_m_tvalid on consecutive cycles updates consecutive channels.
- Input-to-filter latency is 1 cycle minimum plus any wait for earlier channels.

## Test plan

- NCH=2, reset then in_valid=2'b11 with ch0=24'h000100, ch1=24'h000200, f_tready=1 -> f_tdata 000100 then 000200 on consecutive cycles; sel back to 0; overrun=0.
- Only ch1 strobed (in_valid=2'b10) -> f_tvalid stays 0 (sel=0 stalls). Then ch0 strobed -> ch0 issued, then ch1.
- f_tready=0 and second in_valid[0] with 24'h000ABC before the handshake -> overrun[0]=1, f_tdata=000ABC. clr_flags pulse -> overrun[0]=0.
- f_m_tdata sequence 32'h00012345, 32'h01000000, 32'hFE000000 with f_m_tvalid each cycle:
  - out_data ch0=012345 with out_valid=01.
  - ch1=7FFFFF with sat[1]=1.
  - ch0=800000 with sat[0]=1.
- Consume of ch0 with in_valid[0] in the same cycle -> full[0] stays 1, new value issued next round, no overrun.
- rst asserted with full=11 and sel=1 -> next cycle: all outputs 0, f_tvalid=0, sel=0, ochan=0.

Source files
------------

// File: rtl/halfband_chan_sched.sv
// Time-division scheduler sharing one interleaved halfband filter core
// across NCH PCM channels: in-order issue, in-order demux with clipping.
module halfband_chan_sched #(
  parameter int NCH = 2,
  parameter int DW  = 24,
  parameter int FW  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH*DW-1:0] in_data,
  input  logic [NCH-1:0]    in_valid,
  output logic [DW-1:0]     f_tdata,
  output logic              f_tvalid,
  input  logic              f_tready,
  input  logic [FW-1:0]     f_m_tdata,
  input  logic              f_m_tvalid,
  output logic [NCH*DW-1:0] out_data,
  output logic [NCH-1:0]    out_valid,
  output logic [NCH-1:0]    overrun,
  output logic [NCH-1:0]    sat,
  input  logic              clr_flags
);

  localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [SW-1:0] LAST = SW'(NCH - 1);
  localparam logic signed [FW-1:0] SMAX = FW'(2 ** (DW - 1) - 1);
  localparam logic signed [FW-1:0] SMIN = ~SMAX;

  logic [NCH-1:0][DW-1:0] hold;
  logic [NCH-1:0][DW-1:0] odata;
  logic [NCH-1:0]         full;
  logic [SW-1:0]          sel;
  logic [SW-1:0]          ochan;

  logic [NCH-1:0]         take;
  logic [NCH-1:0]         ovr_set;
  logic [NCH-1:0]         sat_set;
  logic                   consume;
  logic                   clipped;
  logic [DW-1:0]          clip;
  logic signed [FW-1:0]   mdata;

  // Issue side is a pure mux of registers; no path from in_* inputs.
  assign f_tvalid = full[sel];
  assign f_tdata  = hold[sel];
  assign consume  = f_tvalid & f_tready;
  assign mdata    = f_m_tdata;
  assign out_data = odata;

  always_comb begin
    take    = '0;
    sat_set = '0;
    clipped = 1'b0;
    clip    = mdata[DW-1:0];
    if (consume)
      take[sel] = 1'b1;
    // A strobe that lands on the slot being consumed is a refill, not a loss.
    ovr_set = in_valid & full & ~take;
    unique case (1'b1)
      (mdata > SMAX): begin
        clip    = {1'b0, {(DW-1){1'b1}}};
        clipped = 1'b1;
      end
      (mdata < SMIN): begin
        clip    = {1'b1, {(DW-1){1'b0}}};
        clipped = 1'b1;
      end
      default: ;
    endcase
    if (f_m_tvalid && clipped)
      sat_set[ochan] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold      <= '0;
      full      <= '0;
      sel       <= '0;
      ochan     <= '0;
      odata     <= '0;
      out_valid <= '0;
      overrun   <= '0;
      sat       <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (in_valid[i]) begin
          hold[i] <= in_data[i*DW +: DW];
          full[i] <= 1'b1;
        end else if (take[i]) begin
          full[i] <= 1'b0;
        end
      end
      if (consume)
        sel <= (sel == LAST) ? '0 : sel + 1'b1;
      out_valid <= '0;
      if (f_m_tvalid) begin
        odata[ochan]     <= clip;
        out_valid[ochan] <= 1'b1;
        ochan            <= (ochan == LAST) ? '0 : ochan + 1'b1;
      end
      overrun <= (clr_flags ? '0 : overrun) | ovr_set;
      sat     <= (clr_flags ? '0 : sat) | sat_set;
    end
  end

endmodule
